// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the memory port sequencer and its arbiter.
package mem_seq_pkg;

    localparam int unsigned ADDR_W_DEF = 30;
    localparam int unsigned DATA_W_DEF = 32;
    localparam logic [1:0]  ALIGN_MASK = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_LS = 1'b1
    } src_t;

    function automatic logic is_aligned(input logic [31:0] byte_addr);
        return (byte_addr[1:0] & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin arbiter: the side not granted last wins a contention.
module mem_arb_rr2
    import mem_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    src_t last_grant_q;
    src_t last_grant_d;

    // Each grant looks only at the other side's request, so a ready never depends on its own valid.
    always_comb begin
        grant    = 2'b00;
        grant[0] = !req[1] || (last_grant_q == SRC_LS);
        grant[1] = !req[0] || (last_grant_q == SRC_IF);
    end

    // Remember which side actually won the accepted transfer.
    always_comb begin
        last_grant_d = last_grant_q;
        if (update) begin
            if (req[1] && grant[1]) begin
                last_grant_d = SRC_LS;
            end else begin
                last_grant_d = SRC_IF;
            end
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Last-grant register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= SRC_IF;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/mem_port_sequencer.sv
// Single-port memory front-end: arbitrates fetch and load/store requests and
// sequences one outstanding word access at a time through the unified memory.
module mem_port_sequencer
    import mem_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [31:0]       if_req_addr,
    output logic              if_rsp_valid,
    input  logic              if_rsp_ready,
    output logic [DATA_W-1:0] if_rsp_data,
    output logic              if_rsp_err,
    input  logic              ls_req_valid,
    output logic              ls_req_ready,
    input  logic [31:0]       ls_req_addr,
    input  logic              ls_req_we,
    input  logic [DATA_W-1:0] ls_req_wdata,
    output logic              ls_rsp_valid,
    input  logic              ls_rsp_ready,
    output logic [DATA_W-1:0] ls_rsp_data,
    output logic              ls_rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    output logic              mem_gp_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_t              state_q, state_d;
    src_t                src_q, src_d;
    logic                we_q, we_d;
    logic                run_q;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_wren_q, mem_wren_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [1:0]          grant_s;
    logic                arb_update_s;
    logic                if_fire_s, ls_fire_s;
    logic                rsp_ready_s;
    logic [31:0]         sel_addr_s;

    mem_arb_rr2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({ls_req_valid, if_req_valid}),
        .update (arb_update_s),
        .grant  (grant_s)
    );

    // run_q keeps both readies low until the first clock after reset release.
    assign if_req_ready = run_q && (state_q == IDLE) && grant_s[0];
    assign ls_req_ready = run_q && (state_q == IDLE) && grant_s[1];
    assign if_fire_s    = if_req_valid && if_req_ready;
    assign ls_fire_s    = ls_req_valid && ls_req_ready;
    assign sel_addr_s   = ls_fire_s ? ls_req_addr : if_req_addr;
    assign rsp_ready_s  = (src_q == SRC_LS) ? ls_rsp_ready : if_rsp_ready;

    assign if_rsp_valid = rsp_valid_q && (src_q == SRC_IF);
    assign ls_rsp_valid = rsp_valid_q && (src_q == SRC_LS);
    assign if_rsp_err   = rsp_err_q && (src_q == SRC_IF);
    assign ls_rsp_err   = rsp_err_q && (src_q == SRC_LS);
    assign if_rsp_data  = rsp_data_q;
    assign ls_rsp_data  = rsp_data_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_wren     = mem_wren_q;
    assign mem_gp_we    = mem_wren_q;
    assign busy         = (state_q != IDLE);

    // Next-state and datapath-register logic for the access sequencer.
    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        we_d         = we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wren_d   = 1'b0;
        rsp_valid_d  = rsp_valid_q;
        rsp_err_d    = rsp_err_q;
        rsp_data_d   = rsp_data_q;
        arb_update_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (if_fire_s || ls_fire_s) begin
                    arb_update_s = 1'b1;
                    src_d        = ls_fire_s ? SRC_LS : SRC_IF;
                    we_d         = ls_fire_s && ls_req_we;
                    if (is_aligned(sel_addr_s)) begin
                        state_d    = ISSUE;
                        mem_addr_d = ADDR_W'(sel_addr_s[31:2]);
                        mem_wren_d = ls_fire_s && ls_req_we;
                        if (ls_fire_s && ls_req_we) begin
                            mem_wdata_d = ls_req_wdata;
                        end else begin
                            mem_wdata_d = mem_wdata_q;
                        end
                    end else begin
                        // Misaligned: answer straight away without touching memory.
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = '0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_data_d  = we_q ? '0 : mem_rdata;
            end
            RESP: begin
                if (rsp_ready_s) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            src_q       <= SRC_IF;
            we_q        <= 1'b0;
            run_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wren_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            we_q        <= we_d;
            run_q       <= 1'b1;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wren_q  <= mem_wren_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Directed self-checking bench for mem_port_sequencer with a registered-read memory model.
module tb_mem_port_sequencer;

    logic        clk;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready, if_rsp_err;
    logic [31:0] if_req_addr, if_rsp_data;
    logic        ls_req_valid, ls_req_ready, ls_req_we, ls_rsp_valid, ls_rsp_ready, ls_rsp_err;
    logic [31:0] ls_req_addr, ls_req_wdata, ls_rsp_data;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_wren, mem_gp_we, busy;
    logic [31:0] mem [0:63];

    int pass_cnt  = 0;
    int total_cnt = 0;

    mem_port_sequencer #(.ADDR_W(30), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready), .if_rsp_data(if_rsp_data),
        .if_rsp_err(if_rsp_err),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_addr(ls_req_addr),
        .ls_req_we(ls_req_we), .ls_req_wdata(ls_req_wdata),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_ready(ls_rsp_ready), .ls_rsp_data(ls_rsp_data),
        .ls_rsp_err(ls_rsp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_gp_we(mem_gp_we),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: filled while reset is held, synchronous write, one-cycle registered read.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) begin
                mem[i] <= (i == 2) ? 32'h2418_0001 : (32'h1000_0000 + 32'(i));
            end
        end else if (mem_wren) begin
            mem[mem_addr[5:0]] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr[5:0]];
    end

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid, if_rsp_err, ls_rsp_err,
             mem_wren, mem_gp_we, busy} !== 9'b0) begin
            $display("FAIL reset_flags: got %b want 000000000", {if_req_ready, ls_req_ready,
                     if_rsp_valid, ls_rsp_valid, if_rsp_err, ls_rsp_err, mem_wren, mem_gp_we, busy});
        end else pass_cnt++;
        total_cnt++;
        if (if_rsp_data !== 32'h0) $display("FAIL reset_rsp_data: got %h want 0", if_rsp_data);
        else pass_cnt++;
        total_cnt++;
        if (mem_addr !== 30'h0) $display("FAIL reset_mem_addr: got %h want 0", mem_addr);
        else pass_cnt++;
        total_cnt++;
        if (mem_wdata !== 32'h0) $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata);
        else pass_cnt++;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_contention();
        bit gsel [0:3];
        int n = 0;
        logic ls_ok = 1'b0;
        logic if_ok = 1'b0;
        if_req_valid = 1'b1; if_req_addr = 32'h0000_0000;
        ls_req_valid = 1'b1; ls_req_addr = 32'h0000_0004; ls_req_we = 1'b0;
        if_rsp_ready = 1'b1; ls_rsp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (ls_req_ready || if_req_ready) begin
                if (n < 4) gsel[n] = ls_req_ready;
                n++;
            end
            if (c == 3) ls_ok = ls_rsp_valid && (ls_rsp_data === 32'h1000_0001);
            if (c == 7) if_ok = if_rsp_valid && (if_rsp_data === 32'h1000_0000);
            if (c == 11) begin if_req_valid = 1'b0; ls_req_valid = 1'b0; end
            @(posedge clk);
            #1;
        end
        if_rsp_ready = 1'b0; ls_rsp_ready = 1'b0;
        total_cnt++;
        if (n !== 3) $display("FAIL rr_pulse_count: got %0d want 3", n);
        else pass_cnt++;
        total_cnt++;
        if ({gsel[0], gsel[1], gsel[2]} !== 3'b101)
            $display("FAIL rr_order: got %b want 101 (1=ls)", {gsel[0], gsel[1], gsel[2]});
        else pass_cnt++;
        total_cnt++;
        if (ls_ok !== 1'b1) $display("FAIL rr_ls_rsp: got %b want 1", ls_ok);
        else pass_cnt++;
        total_cnt++;
        if (if_ok !== 1'b1) $display("FAIL rr_if_rsp: got %b want 1", if_ok);
        else pass_cnt++;
    endtask

    task automatic test_fetch();
        if_req_valid = 1'b1; if_req_addr = 32'h0000_0008;
        #1;
        total_cnt++;
        if (if_req_ready !== 1'b1) $display("FAIL fetch_ready: got %b want 1", if_req_ready);
        else pass_cnt++;
        @(posedge clk); #1;
        if_req_valid = 1'b0;
        total_cnt++;
        if ({mem_addr, mem_wren, busy} !== {30'd2, 1'b0, 1'b1})
            $display("FAIL fetch_issue: got addr %h wren %b busy %b want 2 0 1", mem_addr, mem_wren, busy);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (if_rsp_valid !== 1'b0) $display("FAIL fetch_early_valid: got %b want 0", if_rsp_valid);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if ({if_rsp_valid, if_rsp_err, ls_rsp_valid} !== 3'b100)
            $display("FAIL fetch_rsp_flags: got %b want 100", {if_rsp_valid, if_rsp_err, ls_rsp_valid});
        else pass_cnt++;
        total_cnt++;
        if (if_rsp_data !== 32'h2418_0001) $display("FAIL fetch_data: got %h want 24180001", if_rsp_data);
        else pass_cnt++;
        if_rsp_ready = 1'b1;
        @(posedge clk); #1;
        if_rsp_ready = 1'b0;
        total_cnt++;
        if ({busy, if_rsp_valid} !== 2'b00) $display("FAIL fetch_done: got %b want 00", {busy, if_rsp_valid});
        else pass_cnt++;
    endtask

    task automatic test_store_load();
        ls_req_valid = 1'b1; ls_req_we = 1'b1; ls_req_addr = 32'h0000_0040; ls_req_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        ls_req_valid = 1'b0; ls_req_we = 1'b0;
        total_cnt++;
        if ({mem_wren, mem_gp_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 30'h10, 32'hDEAD_BEEF})
            $display("FAIL store_issue: got wren %b gp %b addr %h wdata %h want 1 1 10 deadbeef",
                     mem_wren, mem_gp_we, mem_addr, mem_wdata);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if ({mem_wren, mem_gp_we} !== 2'b00) $display("FAIL store_wren_width: got %b want 00", {mem_wren, mem_gp_we});
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if ({ls_rsp_valid, ls_rsp_err, if_rsp_valid, ls_rsp_data} !== {3'b100, 32'h0})
            $display("FAIL store_ack: got v %b e %b ifv %b d %h want 1 0 0 0",
                     ls_rsp_valid, ls_rsp_err, if_rsp_valid, ls_rsp_data);
        else pass_cnt++;
        ls_rsp_ready = 1'b1;
        @(posedge clk); #1;
        ls_rsp_ready = 1'b0;
        ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_addr = 32'h0000_0040;
        @(posedge clk); #1;
        ls_req_valid = 1'b0;
        total_cnt++;
        if ({mem_wren, mem_addr} !== {1'b0, 30'h10})
            $display("FAIL load_issue: got wren %b addr %h want 0 10", mem_wren, mem_addr);
        else pass_cnt++;
        repeat (2) begin @(posedge clk); #1; end
        total_cnt++;
        if ({ls_rsp_valid, ls_rsp_err, ls_rsp_data} !== {2'b10, 32'hDEAD_BEEF})
            $display("FAIL load_data: got v %b e %b d %h want 1 0 deadbeef", ls_rsp_valid, ls_rsp_err, ls_rsp_data);
        else pass_cnt++;
        ls_rsp_ready = 1'b1;
        @(posedge clk); #1;
        ls_rsp_ready = 1'b0;
    endtask

    task automatic test_misaligned();
        ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_addr = 32'h0000_0042;
        #1;
        total_cnt++;
        if (ls_req_ready !== 1'b1) $display("FAIL misalign_ready: got %b want 1", ls_req_ready);
        else pass_cnt++;
        @(posedge clk); #1;
        ls_req_valid = 1'b0;
        total_cnt++;
        if ({ls_rsp_valid, ls_rsp_err, if_rsp_valid, mem_wren, busy} !== 5'b11001)
            $display("FAIL misalign_rsp: got %b want 11001", {ls_rsp_valid, ls_rsp_err, if_rsp_valid, mem_wren, busy});
        else pass_cnt++;
        total_cnt++;
        if (ls_rsp_data !== 32'h0) $display("FAIL misalign_data: got %h want 0", ls_rsp_data);
        else pass_cnt++;
        ls_rsp_ready = 1'b1;
        @(posedge clk); #1;
        ls_rsp_ready = 1'b0;
        total_cnt++;
        if ({busy, mem_wren, ls_rsp_valid} !== 3'b000)
            $display("FAIL misalign_done: got %b want 000", {busy, mem_wren, ls_rsp_valid});
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        if_req_valid = 1'b1; if_req_addr = 32'h0000_0008;
        @(posedge clk); #1;
        if_req_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        for (int k = 0; k < 5; k++) begin
            total_cnt++;
            if ({if_rsp_valid, if_req_ready, ls_req_ready, busy, if_rsp_data} !== {4'b1001, 32'h2418_0001})
                $display("FAIL hold_cycle%0d: got v %b ir %b lr %b busy %b d %h want 1 0 0 1 24180001",
                         k, if_rsp_valid, if_req_ready, ls_req_ready, busy, if_rsp_data);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        if_rsp_ready = 1'b1;
        @(posedge clk); #1;
        if_rsp_ready = 1'b0;
        total_cnt++;
        if ({busy, if_rsp_valid} !== 2'b00) $display("FAIL hold_release: got %b want 00", {busy, if_rsp_valid});
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic seen = 1'b0;
        ls_req_valid = 1'b1; ls_req_we = 1'b1; ls_req_addr = 32'h0000_0080; ls_req_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        total_cnt++;
        if (mem_wren !== 1'b1) $display("FAIL midrst_pre_wren: got %b want 1", mem_wren);
        else pass_cnt++;
        rst = 1'b0;
        #1;
        ls_req_valid = 1'b0; ls_req_we = 1'b0;
        total_cnt++;
        if ({mem_wren, mem_gp_we, busy, if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid,
             ls_rsp_err} !== 8'b0)
            $display("FAIL midrst_flags: got %b want 00000000", {mem_wren, mem_gp_we, busy, if_req_ready,
                     ls_req_ready, if_rsp_valid, ls_rsp_valid, ls_rsp_err});
        else pass_cnt++;
        total_cnt++;
        if ({mem_addr, mem_wdata} !== 62'h0)
            $display("FAIL midrst_mem_bus: got addr %h wdata %h want 0 0", mem_addr, mem_wdata);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            if (if_rsp_valid || ls_rsp_valid) seen = 1'b1;
        end
        total_cnt++;
        if (seen !== 1'b0) $display("FAIL midrst_no_rsp: got %b want 0", seen);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b0;
        if_req_valid = 1'b0; if_req_addr = 32'h0; if_rsp_ready = 1'b0;
        ls_req_valid = 1'b0; ls_req_addr = 32'h0; ls_req_we = 1'b0; ls_req_wdata = 32'h0;
        ls_rsp_ready = 1'b0;
        test_reset();
        test_contention();
        test_fetch();
        test_store_load();
        test_misaligned();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
